// File: rtl/fir_ctrl.sv
// AXI-lite control block for the FIR engine: ap_ctrl / data_length registers,
// tap BRAM arbitration between AXI-lite (IDLE) and the engine (RUN), and the run FSM.
module fir_ctrl #(
    parameter int pADDR_WIDTH = 12,
    parameter int pDATA_WIDTH = 32,
    parameter int Tape_Num    = 11
) (
    input  logic                   axis_clk,
    input  logic                   axis_rst_n,
    // AXI-lite write
    input  logic                   awvalid,
    output logic                   awready,
    input  logic [pADDR_WIDTH-1:0] awaddr,
    input  logic                   wvalid,
    output logic                   wready,
    input  logic [pDATA_WIDTH-1:0] wdata,
    // AXI-lite read
    input  logic                   arvalid,
    output logic                   arready,
    input  logic [pADDR_WIDTH-1:0] araddr,
    output logic                   rvalid,
    input  logic                   rready,
    output logic [pDATA_WIDTH-1:0] rdata,
    // tap BRAM
    output logic [3:0]             tap_WE,
    output logic                   tap_EN,
    output logic [pADDR_WIDTH-1:0] tap_A,
    output logic [pDATA_WIDTH-1:0] tap_Di,
    input  logic [pDATA_WIDTH-1:0] tap_Do,
    // engine
    input  logic                   eng_tap_EN,
    input  logic [pADDR_WIDTH-1:0] eng_tap_A,
    input  logic                   out_beat,
    output logic                   eng_start,
    output logic [31:0]            eng_len
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    localparam logic [pADDR_WIDTH-1:0] ADDR_CTRL    = pADDR_WIDTH'(32'h00);
    localparam logic [pADDR_WIDTH-1:0] ADDR_LEN     = pADDR_WIDTH'(32'h10);
    localparam logic [pADDR_WIDTH-1:0] ADDR_TAP     = pADDR_WIDTH'(32'h20);
    localparam logic [pADDR_WIDTH-1:0] ADDR_TAP_END = pADDR_WIDTH'(32 + 4 * Tape_Num);

    function automatic logic is_tap(input logic [pADDR_WIDTH-1:0] a);
        return (a >= ADDR_TAP) && (a < ADDR_TAP_END) && (a[1:0] == 2'b00);
    endfunction

    logic [0:0]             state_q, state_d;
    logic                   ap_done_q, ap_done_d;
    logic [31:0]            len_q, len_d;
    logic [31:0]            beat_q, beat_d;
    logic                   eng_start_q, eng_start_d;
    logic                   awready_q, awready_d;
    logic                   arready_q, arready_d;
    logic                   rvalid_q, rvalid_d;
    logic                   rd_pend_q, rd_pend_d;
    logic                   rd_run_q, rd_run_d;
    logic                   rd_ctrl_q, rd_ctrl_d;
    logic [pDATA_WIDTH-1:0] rdata_q, rdata_d;

    logic                   in_run;
    logic                   wr_req, wr_hs, rd_hs;
    logic [31:0]            beat_sum;
    logic                   run_done;
    logic [pDATA_WIDTH-1:0] reg_rdata;

    assign in_run   = (state_q == RUN);
    assign wr_req   = awvalid & wvalid & ~awready_q;
    assign wr_hs    = awready_q & awvalid & wvalid;
    assign rd_hs    = arready_q & arvalid;
    assign beat_sum = beat_q + {31'b0, out_beat};
    // Zero length finishes in the eng_start cycle itself, since 0 == 0.
    assign run_done = in_run && (beat_sum == len_q);

    always_comb begin
        unique case (araddr)
            ADDR_CTRL: reg_rdata = pDATA_WIDTH'({~in_run, ap_done_q, in_run});
            ADDR_LEN:  reg_rdata = pDATA_WIDTH'(len_q);
            default:   reg_rdata = '0;
        endcase
    end

    always_comb begin
        // NOTE: every target gets a default first so no path leaves it unassigned (no latches).
        state_d     = state_q;
        ap_done_d   = ap_done_q;
        len_d       = len_q;
        beat_d      = beat_q;
        eng_start_d = 1'b0;
        rvalid_d    = rvalid_q;
        rd_pend_d   = rd_pend_q;
        rd_run_d    = rd_run_q;
        rd_ctrl_d   = rd_ctrl_q;
        rdata_d     = rdata_q;

        // A write that is acceptable this cycle blocks the read from being accepted.
        awready_d = wr_req;
        arready_d = arvalid & ~arready_q & ~rvalid_q & ~rd_pend_q & ~wr_req;

        if (rvalid_q && rready) begin
            rvalid_d = 1'b0;
            if (rd_ctrl_q) ap_done_d = 1'b0;
        end

        if (in_run) begin
            beat_d = beat_sum;
            if (run_done) begin
                state_d   = IDLE;
                ap_done_d = 1'b1;
            end
        end else if (wr_hs) begin
            if (awaddr == ADDR_CTRL && wdata[0]) begin
                state_d     = RUN;
                eng_start_d = 1'b1;
                beat_d      = '0;
            end
            if (awaddr == ADDR_LEN) len_d = 32'(wdata);
        end

        if (rd_hs) begin
            rd_ctrl_d = (araddr == ADDR_CTRL);
            if (is_tap(araddr)) begin
                rd_pend_d = 1'b1;
                rd_run_d  = in_run;
            end else begin
                rvalid_d = 1'b1;
                rdata_d  = reg_rdata;
            end
        end

        // Tap data arrives one cycle after the BRAM request; reads issued in RUN never touched it.
        if (rd_pend_q) begin
            rd_pend_d = 1'b0;
            rvalid_d  = 1'b1;
            rdata_d   = rd_run_q ? '1 : tap_Do;
        end
    end

    always_comb begin
        tap_EN = 1'b0;
        tap_WE = 4'h0;
        tap_A  = '0;
        tap_Di = wdata;
        if (in_run) begin
            tap_EN = eng_tap_EN;
            tap_A  = eng_tap_A;
        end else if (wr_hs && is_tap(awaddr)) begin
            tap_EN = 1'b1;
            tap_WE = 4'hF;
            tap_A  = awaddr - ADDR_TAP;
        end else if (rd_hs && is_tap(araddr)) begin
            tap_EN = 1'b1;
            tap_A  = araddr - ADDR_TAP;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge axis_clk or negedge axis_rst_n) begin
        if (!axis_rst_n) begin
            state_q     <= IDLE;
            ap_done_q   <= 1'b0;
            len_q       <= '0;
            beat_q      <= '0;
            eng_start_q <= 1'b0;
            awready_q   <= 1'b0;
            arready_q   <= 1'b0;
            rvalid_q    <= 1'b0;
            rd_pend_q   <= 1'b0;
            rd_run_q    <= 1'b0;
            rd_ctrl_q   <= 1'b0;
            rdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            ap_done_q   <= ap_done_d;
            len_q       <= len_d;
            beat_q      <= beat_d;
            eng_start_q <= eng_start_d;
            awready_q   <= awready_d;
            arready_q   <= arready_d;
            rvalid_q    <= rvalid_d;
            rd_pend_q   <= rd_pend_d;
            rd_run_q    <= rd_run_d;
            rd_ctrl_q   <= rd_ctrl_d;
            rdata_q     <= rdata_d;
        end
    end

    assign awready   = awready_q;
    assign wready    = awready_q;
    assign arready   = arready_q;
    assign rvalid    = rvalid_q;
    assign rdata     = rdata_q;
    assign eng_start = eng_start_q;
    assign eng_len   = len_q;

endmodule

// File: tb/tb_fir_ctrl.sv
// Directed bench for fir_ctrl: AXI-lite register/tap access, run FSM, arbitration and reset abort.
module tb_fir_ctrl;

    logic        axis_clk = 1'b0;
    logic        axis_rst_n = 1'b0;
    logic        awvalid = 1'b0, wvalid = 1'b0, arvalid = 1'b0, rready = 1'b1;
    logic        awready, wready, arready, rvalid;
    logic [11:0] awaddr = '0, araddr = '0, eng_tap_A = '0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata, tap_Di, eng_len;
    logic [31:0] tap_Do = '0;
    logic [11:0] tap_A;
    logic [3:0]  tap_WE;
    logic        tap_EN, eng_start;
    logic        eng_tap_EN = 1'b0, out_beat = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] mem [0:15];

    always #5 axis_clk = ~axis_clk;

    fir_ctrl dut (
        .axis_clk(axis_clk), .axis_rst_n(axis_rst_n),
        .awvalid(awvalid), .awready(awready), .awaddr(awaddr),
        .wvalid(wvalid), .wready(wready), .wdata(wdata),
        .arvalid(arvalid), .arready(arready), .araddr(araddr),
        .rvalid(rvalid), .rready(rready), .rdata(rdata),
        .tap_WE(tap_WE), .tap_EN(tap_EN), .tap_A(tap_A), .tap_Di(tap_Di), .tap_Do(tap_Do),
        .eng_tap_EN(eng_tap_EN), .eng_tap_A(eng_tap_A), .out_beat(out_beat),
        .eng_start(eng_start), .eng_len(eng_len)
    );

    // Single-port tap BRAM with one-cycle read latency.
    initial for (int i = 0; i < 16; i++) mem[i] = '0;
    always @(posedge axis_clk) begin
        if (tap_EN) begin
            if (tap_WE == 4'hF) mem[tap_A[5:2]] <= tap_Di;
            tap_Do <= mem[tap_A[5:2]];
        end
    end

    task automatic axi_write(input logic [11:0] a, input logic [31:0] d);
        bit ok = 0;
        @(negedge axis_clk);
        awaddr = a; wdata = d; awvalid = 1'b1; wvalid = 1'b1;
        for (int i = 0; i < 16; i++) begin
            @(negedge axis_clk);
            if (awready) begin ok = 1; break; end
        end
        n_checks++;
        if (!ok) begin
            n_fail++; $display("FAIL write_timeout addr=%h: awready stayed 0, required 1", a);
        end else if (wready !== 1'b1) begin
            n_fail++; $display("FAIL write_wready addr=%h: wready=%b, required 1", a, wready);
        end
        @(negedge axis_clk);
        awvalid = 1'b0; wvalid = 1'b0;
        n_checks++;
        if (awready !== 1'b0 || wready !== 1'b0) begin
            n_fail++; $display("FAIL write_pulse addr=%h: awready=%b wready=%b, required 0 0", a, awready, wready);
        end
    endtask

    task automatic axi_read(input logic [11:0] a, input int hold, output logic [31:0] data, output int lat);
        bit ok = 0;
        @(negedge axis_clk);
        araddr = a; arvalid = 1'b1; rready = (hold == 0);
        for (int i = 0; i < 16; i++) begin
            @(negedge axis_clk);
            if (arready) begin ok = 1; break; end
        end
        lat = 0; data = 'x;
        if (ok) begin
            ok = 0;
            for (int i = 1; i <= 8; i++) begin
                @(negedge axis_clk);
                arvalid = 1'b0;
                if (rvalid) begin ok = 1; lat = i; break; end
            end
        end
        arvalid = 1'b0;
        n_checks++;
        if (!ok) begin
            n_fail++; $display("FAIL read_timeout addr=%h: no arready/rvalid, required handshake", a);
        end else begin
            data = rdata;
            if (hold > 0) begin
                repeat (hold) @(negedge axis_clk);
                n_checks++;
                if (rvalid !== 1'b1 || rdata !== data) begin
                    n_fail++; $display("FAIL read_hold addr=%h: rvalid=%b rdata=%h, required 1 %h", a, rvalid, rdata, data);
                end
                rready = 1'b1;
                @(negedge axis_clk);
                n_checks++;
                if (rvalid !== 1'b0) begin
                    n_fail++; $display("FAIL read_release addr=%h: rvalid=%b, required 0", a, rvalid);
                end
            end
        end
        rready = 1'b1;
    endtask

    task automatic send_beats(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge axis_clk);
            out_beat = 1'b1;
        end
        @(negedge axis_clk);
        out_beat = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        int lat;
        #2;
        n_checks++;
        if ({awready, wready, arready, rvalid, eng_start, tap_EN} !== 6'b0 || tap_WE !== 4'h0 ||
            rdata !== 32'h0 || eng_len !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: aw=%b w=%b ar=%b rv=%b st=%b en=%b we=%h rdata=%h len=%h, required all 0",
                     awready, wready, arready, rvalid, eng_start, tap_EN, tap_WE, rdata, eng_len);
        end
        repeat (2) @(negedge axis_clk);
        axis_rst_n = 1'b1;
        axi_read(12'h000, 2, d, lat);
        n_checks++;
        if (d !== 32'h4 || lat !== 1) begin
            n_fail++; $display("FAIL reset_ap_ctrl: rdata=%h lat=%0d, required 00000004 lat 1", d, lat);
        end
        axi_read(12'h010, 0, d, lat);
        n_checks++;
        if (d !== 32'h0) begin
            n_fail++; $display("FAIL reset_len: rdata=%h, required 00000000", d);
        end
    endtask

    task automatic test_taps();
        int signed taps [11] = '{0, -10, -9, 23, 56, 63, 56, 23, -9, -10, 0};
        logic [31:0] d;
        int lat;
        for (int i = 0; i < 11; i++) axi_write(12'(32'h20 + 4 * i), 32'(taps[i]));
        for (int i = 0; i < 11; i++) begin
            axi_read(12'(32'h20 + 4 * i), 0, d, lat);
            n_checks++;
            if (d !== 32'(taps[i]) || lat !== 2) begin
                n_fail++; $display("FAIL tap_readback[%0d]: rdata=%h lat=%0d, required %h lat 2", i, d, lat, 32'(taps[i]));
            end
        end
    endtask

    task automatic test_unmapped();
        logic [31:0] d;
        int lat;
        axi_write(12'h004, 32'hDEAD_BEEF);
        axi_read(12'h004, 0, d, lat);
        n_checks++;
        if (d !== 32'h0 || lat !== 1) begin
            n_fail++; $display("FAIL unmapped_04: rdata=%h lat=%0d, required 00000000 lat 1", d, lat);
        end
        axi_write(12'h04C, 32'h0000_1234);
        axi_read(12'h04C, 0, d, lat);
        n_checks++;
        if (d !== 32'h0 || lat !== 1) begin
            n_fail++; $display("FAIL unmapped_4C: rdata=%h lat=%0d, required 00000000 lat 1", d, lat);
        end
        n_checks++;
        if (mem[11] !== 32'h0) begin
            n_fail++; $display("FAIL unmapped_bram: bram[11]=%h, required 00000000", mem[11]);
        end
        axi_read(12'h048, 0, d, lat);
        n_checks++;
        if (d !== 32'h0 || lat !== 2) begin
            n_fail++; $display("FAIL last_tap: rdata=%h lat=%0d, required 00000000 lat 2", d, lat);
        end
    endtask

    task automatic test_back_to_back();
        int aw_cyc = -1, ar_cyc = -1;
        logic [31:0] got = 'x;
        @(negedge axis_clk);
        awaddr = 12'h010; wdata = 32'd77; awvalid = 1'b1; wvalid = 1'b1;
        araddr = 12'h010; arvalid = 1'b1; rready = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            @(negedge axis_clk);
            if (aw_cyc >= 0) begin awvalid = 1'b0; wvalid = 1'b0; end
            if (ar_cyc >= 0) arvalid = 1'b0;
            if (awready && aw_cyc < 0) aw_cyc = i;
            if (arready && ar_cyc < 0) ar_cyc = i;
            if (rvalid) begin got = rdata; break; end
        end
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        n_checks++;
        if (aw_cyc < 0 || ar_cyc !== aw_cyc + 1) begin
            n_fail++; $display("FAIL collision_order: awready cycle %0d arready cycle %0d, required ar = aw+1", aw_cyc, ar_cyc);
        end
        n_checks++;
        if (got !== 32'd77) begin
            n_fail++; $display("FAIL collision_data: rdata=%h, required 0000004d", got);
        end
    endtask

    task automatic test_run();
        logic [31:0] d;
        int lat;
        eng_tap_EN = 1'b1; eng_tap_A = 12'h008;
        axi_write(12'h010, 32'd600);
        axi_write(12'h000, 32'h1);
        n_checks++;
        if (eng_start !== 1'b1 || eng_len !== 32'd600) begin
            n_fail++; $display("FAIL start_pulse: eng_start=%b eng_len=%0d, required 1 600", eng_start, eng_len);
        end
        @(negedge axis_clk);
        n_checks++;
        if (eng_start !== 1'b0) begin
            n_fail++; $display("FAIL start_width: eng_start=%b, required 0", eng_start);
        end
        n_checks++;
        if (tap_EN !== 1'b1 || tap_A !== 12'h008 || tap_WE !== 4'h0) begin
            n_fail++; $display("FAIL run_owner: EN=%b A=%h WE=%h, required 1 008 0", tap_EN, tap_A, tap_WE);
        end
        axi_read(12'h000, 0, d, lat);
        n_checks++;
        if (d !== 32'h1) begin
            n_fail++; $display("FAIL run_ap_ctrl: rdata=%h, required 00000001", d);
        end
        axi_read(12'h024, 0, d, lat);
        n_checks++;
        if (d !== 32'hFFFF_FFFF) begin
            n_fail++; $display("FAIL run_tap_read: rdata=%h, required ffffffff", d);
        end
        axi_write(12'h010, 32'd5);
        axi_read(12'h010, 0, d, lat);
        n_checks++;
        if (d !== 32'd600) begin
            n_fail++; $display("FAIL run_len_locked: rdata=%0d, required 600", d);
        end
        axi_write(12'h020, 32'd7);
        axi_write(12'h000, 32'h1);
        n_checks++;
        if (eng_start !== 1'b0) begin
            n_fail++; $display("FAIL run_restart: eng_start=%b, required 0", eng_start);
        end
        send_beats(599);
        n_checks++;
        if (tap_EN !== 1'b1) begin
            n_fail++; $display("FAIL run_before_last: tap_EN=%b, required 1 (still RUN)", tap_EN);
        end
        send_beats(1);
        n_checks++;
        if (tap_EN !== 1'b0) begin
            n_fail++; $display("FAIL idle_after_last: tap_EN=%b, required 0 (IDLE)", tap_EN);
        end
        axi_read(12'h000, 0, d, lat);
        n_checks++;
        if (d !== 32'h6) begin
            n_fail++; $display("FAIL done_read1: rdata=%h, required 00000006", d);
        end
        axi_read(12'h000, 0, d, lat);
        n_checks++;
        if (d !== 32'h4) begin
            n_fail++; $display("FAIL done_read2: rdata=%h, required 00000004", d);
        end
        axi_read(12'h020, 0, d, lat);
        n_checks++;
        if (d !== 32'h0 || lat !== 2) begin
            n_fail++; $display("FAIL run_tap_write_dropped: rdata=%h lat=%0d, required 00000000 lat 2", d, lat);
        end
    endtask

    task automatic test_zero_length();
        logic [31:0] d;
        int lat;
        axi_write(12'h010, 32'd0);
        axi_write(12'h000, 32'h1);
        n_checks++;
        if (eng_start !== 1'b1 || tap_EN !== 1'b1) begin
            n_fail++; $display("FAIL zero_start: eng_start=%b tap_EN=%b, required 1 1", eng_start, tap_EN);
        end
        @(negedge axis_clk);
        n_checks++;
        if (tap_EN !== 1'b0) begin
            n_fail++; $display("FAIL zero_idle: tap_EN=%b, required 0 (IDLE)", tap_EN);
        end
        axi_read(12'h000, 0, d, lat);
        n_checks++;
        if (d !== 32'h6) begin
            n_fail++; $display("FAIL zero_done: rdata=%h, required 00000006", d);
        end
        axi_read(12'h000, 0, d, lat);
        n_checks++;
        if (d !== 32'h4) begin
            n_fail++; $display("FAIL zero_done_clear: rdata=%h, required 00000004", d);
        end
    endtask

    task automatic test_reset_abort();
        logic [31:0] d;
        int lat;
        axi_write(12'h010, 32'd600);
        axi_write(12'h000, 32'h1);
        send_beats(300);
        @(negedge axis_clk);
        axis_rst_n = 1'b0;
        #1;
        n_checks++;
        if (tap_EN !== 1'b0 || eng_start !== 1'b0 || eng_len !== 32'h0) begin
            n_fail++; $display("FAIL abort_async: tap_EN=%b eng_start=%b eng_len=%0d, required 0 0 0", tap_EN, eng_start, eng_len);
        end
        @(negedge axis_clk);
        axis_rst_n = 1'b1;
        axi_read(12'h000, 0, d, lat);
        n_checks++;
        if (d !== 32'h4) begin
            n_fail++; $display("FAIL abort_ap_ctrl: rdata=%h, required 00000004", d);
        end
        axi_read(12'h02C, 0, d, lat);
        n_checks++;
        if (d !== 32'd23) begin
            n_fail++; $display("FAIL abort_taps_kept: rdata=%h, required 00000017", d);
        end
        axi_write(12'h010, 32'd600);
        axi_write(12'h000, 32'h1);
        n_checks++;
        if (eng_start !== 1'b1) begin
            n_fail++; $display("FAIL restart_pulse: eng_start=%b, required 1", eng_start);
        end
        send_beats(599);
        n_checks++;
        if (tap_EN !== 1'b1) begin
            n_fail++; $display("FAIL restart_full_len: tap_EN=%b, required 1 (still RUN)", tap_EN);
        end
        send_beats(1);
        axi_read(12'h000, 0, d, lat);
        n_checks++;
        if (d !== 32'h6) begin
            n_fail++; $display("FAIL restart_done: rdata=%h, required 00000006", d);
        end
    endtask

    initial begin
        test_reset();
        test_taps();
        test_unmapped();
        test_back_to_back();
        test_run();
        test_zero_length();
        test_reset_abort();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
